// File: rtl/arith18_mul_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : arith18_mul_seq_if                                          |
// | Brief  : request / result / external-adder bundle for the multiplier |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface arith18_mul_seq_if;
  logic        start;
  logic [17:0] a;
  logic [17:0] b;
  logic [17:0] add_op1;
  logic [17:0] add_op2;
  logic [17:0] add_sum;
  logic [17:0] product;
  logic        overflow;
  logic        busy;
  logic        done;

  modport master (
    output start, a, b, add_sum,
    input  add_op1, add_op2, product, overflow, busy, done
  );

  modport slave (
    input  start, a, b, add_sum,
    output add_op1, add_op2, product, overflow, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/arith18_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : arith18_mul_seq                                             |
// | Brief  : 18x18 shift-add multiplier, 18 fixed iterations, ext. adder |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module arith18_mul_seq (
  input  wire               clk,
  input  wire               reset,
  arith18_mul_seq_if.slave  bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;
  localparam logic [4:0] c_LAST = 5'd17;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [17:0] r_acc;
  logic [17:0] r_mcand;
  logic [17:0] r_mplier;
  logic [4:0]  r_count;
  logic        r_lost;
  logic        r_ovf;
  logic [17:0] r_product;
  logic        r_overflow;
  logic        r_busy;
  logic        r_done;
  logic [17:0] w_op1;
  logic [17:0] w_op2;
  logic        w_run;
  logic        w_add;
  logic        w_ovf_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (bus.start) w_next = c_RUN;
      c_RUN:   if (r_count == c_LAST) w_next = c_DONE;
      c_DONE:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    if (r_state == c_RUN) begin
      w_op1 = r_acc;
      w_op2 = r_mplier[0] ? r_mcand : '0;
    end
  end

  assign w_run = (r_state == c_RUN);
  assign w_add = w_run && r_mplier[0];
  // Overflow sources: adder wrap, or adding after a multiplicand bit fell off the top.
  assign w_ovf_next = r_ovf | (w_add && (bus.add_sum < w_op1)) | (w_add && r_lost);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_count    <= '0;
      r_lost     <= 1'b0;
      r_ovf      <= 1'b0;
      r_product  <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy <= (w_next == c_RUN);
      r_done <= (w_next == c_DONE);
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_mcand  <= bus.a;
            r_mplier <= bus.b;
            r_acc    <= '0;
            r_count  <= '0;
            r_lost   <= 1'b0;
            r_ovf    <= 1'b0;
          end
        end
        c_RUN: begin
          r_acc    <= bus.add_sum;
          r_mcand  <= {r_mcand[16:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[17:1]};
          r_count  <= r_count + 5'd1;
          r_lost   <= r_lost | r_mcand[17];
          r_ovf    <= w_ovf_next;
          if (r_count == c_LAST) begin
            r_product  <= bus.add_sum;
            r_overflow <= w_ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.add_op1  = w_op1;
  assign bus.add_op2  = w_op2;
  assign bus.product  = r_product;
  assign bus.overflow = r_overflow;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_arith18_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_arith18_mul_seq                                          |
// | Brief  : vector table, corner sequences and random run vs a*b model  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_arith18_mul_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  arith18_mul_seq_if bus ();
  // Ideal 18-bit adder stage, carry discarded.
  assign bus.add_sum = bus.add_op1 + bus.add_op2;

  arith18_mul_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] prod;
    logic        ovf;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then follow it to completion.
  task automatic run_op(input logic [17:0] a, input logic [17:0] b,
                        output logic [17:0] prod, output logic ovf,
                        output int busy_cycles, output logic done_seen, output int both_hi);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_cycles = 0;
    both_hi = 0;
    while (bus.busy && busy_cycles < 40) begin
      busy_cycles++;
      if (bus.done) both_hi++;
      tick();
    end
    done_seen = bus.done;
    prod = bus.product;
    ovf = bus.overflow;
    tick();
  endtask

  initial begin
    logic [17:0] prod;
    logic        ovf;
    int          bc;
    logic        ds;
    int          bh;
    int          pulses;
    logic [35:0] p;
    logic [17:0] ra;
    logic [17:0] rb;

    tbl[0] = '{18'd3,       18'd5,       18'd15,      1'b0};
    tbl[1] = '{18'h3FFFF,   18'd1,       18'h3FFFF,   1'b0};
    tbl[2] = '{18'd0,       18'h3FFFF,   18'd0,       1'b0};
    tbl[3] = '{18'd512,     18'd512,     18'd0,       1'b1};
    tbl[4] = '{18'h20000,   18'd2,       18'd0,       1'b1};
    tbl[5] = '{18'h20000,   18'd1,       18'h20000,   1'b0};
    tbl[6] = '{18'h1FF,     18'h1FF,     18'h3FC01,   1'b0};
    tbl[7] = '{18'h200,     18'h1FF,     18'h3FE00,   1'b0};
    tbl[8] = '{18'h3FFFF,   18'h3FFFF,   18'd1,       1'b1};
    tbl[9] = '{18'd1000,    18'd262,     18'd0,       1'b0};
    tbl[9].prod = 18'd262000;

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) tick();
    chk("reset_product", bus.product, 0);
    chk("reset_overflow", bus.overflow, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_add_op1", bus.add_op1, 0);
    chk("reset_add_op2", bus.add_op2, 0);

    // First request lands in the very first cycle after reset release.
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, prod, ovf, bc, ds, bh);
      chk($sformatf("vec%0d_product", i), prod, tbl[i].prod);
      chk($sformatf("vec%0d_overflow", i), ovf, tbl[i].ovf);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 18);
      chk($sformatf("vec%0d_done", i), ds, 1);
      chk($sformatf("vec%0d_busy_done_overlap", i), bh, 0);
      chk($sformatf("vec%0d_done_drop", i), bus.done, 0);
    end
    chk("idle_add_op1", bus.add_op1, 0);
    chk("idle_add_op2", bus.add_op2, 0);

    // Second start mid-run must be ignored.
    bus.a = 18'd7;
    bus.b = 18'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("run0_add_op1", bus.add_op1, 0);
    chk("run0_add_op2", bus.add_op2, 7);
    tick();
    chk("run1_add_op1", bus.add_op1, 7);
    chk("run1_add_op2", bus.add_op2, 0);
    repeat (4) tick();
    bus.a = 18'd1;
    bus.b = 18'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.done) pulses++;
      tick();
    end
    chk("restart_done_pulses", pulses, 1);
    chk("restart_product", bus.product, 63);
    chk("restart_overflow", bus.overflow, 0);
    repeat (5) tick();
    chk("hold_product", bus.product, 63);

    // Reset in the middle of a run aborts it.
    bus.a = 18'd100;
    bus.b = 18'd200;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_product", bus.product, 0);
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      if (bus.done) pulses++;
      tick();
    end
    chk("abort_no_done", pulses, 0);
    run_op(18'd6, 18'd7, prod, ovf, bc, ds, bh);
    chk("post_abort_product", prod, 42);
    chk("post_abort_overflow", ovf, 0);

    // Random operands with mixed bit widths to spread around the 2^18 boundary.
    for (int r = 0; r < 1200; r++) begin
      ra = 18'($urandom) & 18'((1 << $urandom_range(0, 18)) - 1);
      rb = 18'($urandom) & 18'((1 << $urandom_range(0, 18)) - 1);
      p = {18'd0, ra} * {18'd0, rb};
      run_op(ra, rb, prod, ovf, bc, ds, bh);
      chk($sformatf("rand%0d_product a=%0h b=%0h", r, ra, rb), prod, p[17:0]);
      chk($sformatf("rand%0d_overflow a=%0h b=%0h", r, ra, rb), ovf, (p >= 36'h40000));
      if (bc != 18 || ds !== 1'b1) chk($sformatf("rand%0d_timing", r), bc, 18);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
